// File: rtl/sreg_writeback.sv
// sreg_writeback: write-side controller for the scalar register file.
// Arbitrates ALU / LSU / MDU results onto the single register-file write
// port (ALU has fixed priority, LSU and MDU share round-robin) and keeps a
// per-register busy scoreboard so the issue stage can stall on RAW/WAW.
module sreg_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid_i,
  input  logic [4:0]            alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [4:0]            lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  input  logic                  mdu_valid_i,
  output logic                  mdu_ready_o,
  input  logic [4:0]            mdu_rd_i,
  input  logic [DATA_WIDTH-1:0] mdu_data_i,
  input  logic                  issue_valid_i,
  input  logic [4:0]            issue_rd_i,
  input  logic [4:0]            issue_rs1_i,
  input  logic [4:0]            issue_rs2_i,
  output logic                  stall_o,
  output logic [4:0]            rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  reg_write_en_o
);

  // Round-robin pointer encoding: whose turn it is when LSU and MDU collide.
  localparam logic RR_LSU = 1'b0;
  localparam logic RR_MDU = 1'b1;

  logic [REG_COUNT-1:0]  busy_q, busy_d;
  logic                  rr_q, rr_d;
  logic                  wen_q, wen_d;
  logic [4:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  gnt_valid;
  logic [4:0]            gnt_rd;
  logic [DATA_WIDTH-1:0] gnt_data;

  // Readies depend only on valids and the pointer, never on another ready.
  assign lsu_ready_o = !alu_valid_i && lsu_valid_i && (!mdu_valid_i || rr_q == RR_LSU);
  assign mdu_ready_o = !alu_valid_i && mdu_valid_i && (!lsu_valid_i || rr_q == RR_MDU);

  // busy_q[0] is held at zero, so x0 never contributes a stall.
  assign stall_o = busy_q[issue_rs1_i] | busy_q[issue_rs2_i] | busy_q[issue_rd_i];

  assign rd_addr_o      = addr_q;
  assign rd_data_o      = data_q;
  assign reg_write_en_o = wen_q;

  // Select the winning result: ALU first, then whichever of LSU/MDU is ready.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_rd    = '0;
    gnt_data  = '0;
    if (alu_valid_i) begin
      gnt_valid = 1'b1;
      gnt_rd    = alu_rd_i;
      gnt_data  = alu_data_i;
    end else if (lsu_ready_o) begin
      gnt_valid = 1'b1;
      gnt_rd    = lsu_rd_i;
      gnt_data  = lsu_data_i;
    end else if (mdu_ready_o) begin
      gnt_valid = 1'b1;
      gnt_rd    = mdu_rd_i;
      gnt_data  = mdu_data_i;
    end
  end

  // Next state: write-port stage, round-robin pointer and scoreboard.
  always_comb begin
    wen_d  = gnt_valid && (gnt_rd != 5'd0);
    addr_d = addr_q;
    data_d = data_q;
    if (wen_d) begin
      addr_d = gnt_rd;
      data_d = gnt_data;
    end

    rr_d = rr_q;
    if (lsu_ready_o) begin
      rr_d = RR_MDU;
    end else if (mdu_ready_o) begin
      rr_d = RR_LSU;
    end

    // Retire the register being written this cycle, then mark the new issue.
    // The issuer never targets a register that is still busy, so the two
    // never collide on the same bit.
    busy_d = busy_q;
    if (wen_q) begin
      busy_d[addr_q] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != 5'd0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset discards anything accepted in the reset cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      rr_q   <= RR_LSU;
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      rr_q   <= rr_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_sreg_writeback.sv
// Randomized self-checking bench for sreg_writeback against a behavioural
// model of the write arbiter and busy scoreboard.
module tb_sreg_writeback;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid_i, lsu_valid_i, mdu_valid_i, issue_valid_i;
  logic [4:0]    alu_rd_i, lsu_rd_i, mdu_rd_i;
  logic [DW-1:0] alu_data_i, lsu_data_i, mdu_data_i;
  logic [4:0]    issue_rd_i, issue_rs1_i, issue_rs2_i;
  logic          lsu_ready_o, mdu_ready_o, stall_o, reg_write_en_o;
  logic [4:0]    rd_addr_o;
  logic [DW-1:0] rd_data_o;

  always #5 clk = ~clk;

  sreg_writeback #(.DATA_WIDTH(DW), .REG_COUNT(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o), .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i), .stall_o(stall_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .reg_write_en_o(reg_write_en_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: set of busy registers, whose turn it is, write port.
  bit            busy_m[32];
  bit            mdu_turn_m;
  bit            wen_m;
  logic [4:0]    addr_m;
  logic [DW-1:0] data_m;

  // Bench-side source bookkeeping.
  int inflight[$];
  bit lsu_pend, mdu_pend;

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    mdu_turn_m = 1'b0;
    wen_m      = 1'b0;
    addr_m     = '0;
    data_m     = '0;
  endtask

  function automatic bit stall_m(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return (a != 0 && busy_m[a]) || (b != 0 && busy_m[b]) || (c != 0 && busy_m[c]);
  endfunction

  // 0 = nobody, 1 = ALU, 2 = LSU, 3 = MDU
  function automatic int winner();
    if (alu_valid_i) return 1;
    if (lsu_valid_i && mdu_valid_i) return mdu_turn_m ? 3 : 2;
    if (lsu_valid_i) return 2;
    if (mdu_valid_i) return 3;
    return 0;
  endfunction

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle(output int w);
    logic [4:0]    grd;
    logic [DW-1:0] gd;
    #1;
    w = winner();
    chk("lsu_ready", lsu_ready_o, (w == 2));
    chk("mdu_ready", mdu_ready_o, (w == 3));
    chk("stall", stall_o, stall_m(issue_rs1_i, issue_rs2_i, issue_rd_i));
    grd = '0;
    gd  = '0;
    case (w)
      1: begin grd = alu_rd_i; gd = alu_data_i; end
      2: begin grd = lsu_rd_i; gd = lsu_data_i; end
      3: begin grd = mdu_rd_i; gd = mdu_data_i; end
      default: ;
    endcase
    if (wen_m) busy_m[addr_m] = 1'b0;
    if (issue_valid_i && issue_rd_i != 0) busy_m[issue_rd_i] = 1'b1;
    wen_m = (w != 0) && (grd != 0);
    if (wen_m) begin
      addr_m = grd;
      data_m = gd;
    end
    if (w == 2) mdu_turn_m = 1'b1;
    if (w == 3) mdu_turn_m = 1'b0;
    @(posedge clk);
    #1;
    chk("wen", reg_write_en_o, wen_m);
    chk("rd_addr", rd_addr_o, addr_m);
    chk("rd_data", rd_data_o, data_m);
  endtask

  task automatic idle_inputs();
    alu_valid_i = 0; lsu_valid_i = 0; mdu_valid_i = 0; issue_valid_i = 0;
    alu_rd_i = 0; lsu_rd_i = 0; mdu_rd_i = 0;
    alu_data_i = 0; lsu_data_i = 0; mdu_data_i = 0;
    issue_rd_i = 0; issue_rs1_i = 0; issue_rs2_i = 0;
  endtask

  task automatic get_rd(output logic [4:0] r);
    int idx;
    if (inflight.size() == 0 || $urandom_range(0, 7) == 0) begin
      r = 5'd0;
    end else begin
      idx = $urandom_range(0, inflight.size() - 1);
      r = 5'(inflight[idx]);
      inflight.delete(idx);
    end
  endtask

  task automatic rand_cycle(input int alu_pct);
    int w;
    if ($urandom_range(0, 99) < alu_pct) begin
      alu_valid_i = 1;
      get_rd(alu_rd_i);
    end else begin
      alu_valid_i = 0;
      alu_rd_i = 5'($urandom);
    end
    alu_data_i = $urandom;
    if (!lsu_pend && $urandom_range(0, 1) == 1) begin
      lsu_pend = 1;
      get_rd(lsu_rd_i);
      lsu_data_i = $urandom;
    end
    lsu_valid_i = lsu_pend;
    if (!mdu_pend && $urandom_range(0, 1) == 1) begin
      mdu_pend = 1;
      get_rd(mdu_rd_i);
      mdu_data_i = $urandom;
    end
    mdu_valid_i = mdu_pend;
    issue_rd_i  = 5'($urandom_range(1, 31));
    issue_rs1_i = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    issue_rs2_i = 5'($urandom);
    issue_valid_i = !stall_m(issue_rs1_i, issue_rs2_i, issue_rd_i) && ($urandom_range(0, 99) < 60);
    cycle(w);
    if (w == 2) lsu_pend = 0;
    if (w == 3) mdu_pend = 0;
    if (issue_valid_i) inflight.push_back(int'(issue_rd_i));
  endtask

  initial begin
    int w;
    idle_inputs();
    model_reset();
    lsu_pend = 0;
    mdu_pend = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_wen", reg_write_en_o, 0);
    chk("rst_addr", rd_addr_o, 0);
    chk("rst_data", rd_data_o, 0);
    issue_rd_i = 5; issue_rs1_i = 6; issue_rs2_i = 7;
    lsu_valid_i = 1; mdu_valid_i = 1;
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_lsu_ready", lsu_ready_o, 1);
    chk("rst_mdu_ready", mdu_ready_o, 0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1;

    // Round-robin from reset: mark x1/x2 busy, then both sources stream.
    issue_valid_i = 1; issue_rd_i = 1;
    cycle(w);
    issue_rd_i = 2;
    cycle(w);
    idle_inputs();
    lsu_valid_i = 1; lsu_rd_i = 1; lsu_data_i = 32'h1111_0001;
    mdu_valid_i = 1; mdu_rd_i = 2; mdu_data_i = 32'h2222_0002;
    for (int i = 0; i < 4; i++) begin
      cycle(w);
      chk("rr_addr", rd_addr_o, (i % 2 == 0) ? 1 : 2);
    end
    idle_inputs();
    repeat (2) cycle(w);

    // ALU write to x5 and the stall release timing.
    issue_valid_i = 1; issue_rd_i = 5;
    cycle(w);
    idle_inputs();
    alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'hDEADBEEF; issue_rs1_i = 5;
    cycle(w);
    chk("alu_wen", reg_write_en_o, 1);
    chk("alu_addr", rd_addr_o, 5);
    chk("alu_data", rd_data_o, 32'hDEADBEEF);
    alu_valid_i = 0;
    #1;
    chk("alu_stall_n1", stall_o, 1);
    cycle(w);
    chk("alu_stall_n2", stall_o, 0);

    // MDU result to x0 handshakes but does not write.
    mdu_valid_i = 1; mdu_rd_i = 0; mdu_data_i = 32'hCAFE0000; issue_rs1_i = 0;
    cycle(w);
    chk("x0_wen", reg_write_en_o, 0);
    chk("x0_data", rd_data_o, 32'hDEADBEEF);
    idle_inputs();
    cycle(w);

    // Random traffic at several ALU loads.
    for (int i = 0; i < 600; i++) rand_cycle(10);
    for (int i = 0; i < 600; i++) rand_cycle(50);
    for (int i = 0; i < 600; i++) rand_cycle(85);

    // Asynchronous reset in mid-cycle while the write port is active.
    for (int i = 0; i < 100 && !wen_m; i++) rand_cycle(50);
    chk("pre_rst_wen", reg_write_en_o, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_wen", reg_write_en_o, 0);
    chk("arst_addr", rd_addr_o, 0);
    chk("arst_data", rd_data_o, 0);
    model_reset();
    lsu_pend = 0;
    mdu_pend = 0;
    inflight.delete();
    for (int a = 0; a < 32; a += 5) begin
      issue_rs1_i = 5'(a); issue_rs2_i = 5'(31 - a); issue_rd_i = 5'(a + 1);
      #0.1;
      chk("arst_stall", stall_o, 0);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 200; i++) rand_cycle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
